// File: rtl/atm_key_entry.sv
// atm_key_entry: keypad front-end for the ATM control block.
// Assembles a 4-digit account number and a 1-digit PIN from a key stream.
// Issues one auth request and consumes the pass/fail result.
// Counts consecutive failures and locks the keypad after MAX_TRIES of them.
// Ports:
//   clk, rst (sync, active-low)
//   key_valid/key_code: key strobe; codes 0-9 digit, 10 CLEAR, 11 ENTER, 12 CANCEL
//   auth_done/auth_ok: result strobe + qualifier
//   exit: logout request, only honoured in a session
//   acc_number, pin, req_valid: stable request payload + one-cycle strobe
//   session_open, locked, entry_error, fail_count: status (all registered)
module atm_key_entry #(
  parameter int MAX_TRIES    = 3,
  parameter int LOCK_CYCLES  = 1000,
  parameter int RESP_TIMEOUT = 64,
  parameter int IDLE_CYCLES  = 6000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        auth_done,
  input  logic        auth_ok,
  input  logic        exit,
  output logic [11:0] acc_number,
  output logic [3:0]  pin,
  output logic        req_valid,
  output logic        session_open,
  output logic        locked,
  output logic        entry_error,
  output logic [3:0]  fail_count
);

  typedef enum logic [2:0] {S_ACC, S_PIN, S_REQ, S_WAIT, S_SESSION, S_LOCKED} state_e;

  // One timer is shared: idle in ACC/PIN, response in WAIT, lockout in LOCKED.
  localparam int T1 = (LOCK_CYCLES > RESP_TIMEOUT) ? LOCK_CYCLES : RESP_TIMEOUT;
  localparam int TMAX = (T1 > IDLE_CYCLES) ? T1 : IDLE_CYCLES;
  localparam int TW = $clog2(TMAX) + 1;

  state_e        state_q, state_d;
  logic [13:0]   accum_q, accum_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [11:0]   acc_number_q, acc_number_d;
  logic [3:0]    pin_q, pin_d;
  logic          pin_vld_q, pin_vld_d;
  logic          req_valid_q, req_valid_d;
  logic          session_open_q, session_open_d;
  logic          locked_q, locked_d;
  logic          entry_error_q, entry_error_d;
  logic [3:0]    fail_count_q, fail_count_d;
  logic [TW-1:0] timer_q, timer_d;

  logic       is_digit, is_clear, is_enter, is_cancel, full_clear;
  logic [3:0] fail_next;

  assign is_digit  = key_valid && (key_code <= 4'd9);
  assign is_clear  = key_valid && (key_code == 4'd10);
  assign is_enter  = key_valid && (key_code == 4'd11);
  assign is_cancel = key_valid && (key_code == 4'd12);
  assign fail_next = fail_count_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    accum_d        = accum_q;
    cnt_d          = cnt_q;
    acc_number_d   = acc_number_q;
    pin_d          = pin_q;
    pin_vld_d      = pin_vld_q;
    req_valid_d    = 1'b0;
    session_open_d = session_open_q;
    locked_d       = locked_q;
    entry_error_d  = 1'b0;
    fail_count_d   = fail_count_q;
    timer_d        = timer_q;
    full_clear     = 1'b0;

    // Idle timeout only fires on key-less cycles, so it never collides with
    // the key handling below.
    if (state_q == S_ACC || state_q == S_PIN) begin
      if (key_valid) begin
        timer_d = '0;
      end else if (cnt_q != 3'd0 || pin_vld_q) begin
        if (timer_q == TW'(IDLE_CYCLES - 1)) begin
          entry_error_d = 1'b1;
          full_clear    = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end else begin
        timer_d = '0;
      end
    end

    case (state_q)
      S_ACC: begin
        if (is_cancel) begin
          full_clear = 1'b1;
        end else if (is_digit) begin
          // accum <= 999 whenever fewer than 4 digits are held, so 14 bits suffice
          if (cnt_q < 3'd4) begin
            accum_d = accum_q * 14'd10 + {10'd0, key_code};
            cnt_d   = cnt_q + 3'd1;
          end
        end else if (is_clear) begin
          accum_d = '0;
          cnt_d   = '0;
        end else if (is_enter) begin
          if (cnt_q == 3'd4 && accum_q <= 14'd4095) begin
            acc_number_d = accum_q[11:0];
            state_d      = S_PIN;
            timer_d      = '0;
          end else begin
            entry_error_d = 1'b1;
            accum_d       = '0;
            cnt_d         = '0;
          end
        end
      end
      S_PIN: begin
        if (is_cancel) begin
          full_clear = 1'b1;
        end else if (is_digit) begin
          if (!pin_vld_q) begin
            pin_d     = key_code;
            pin_vld_d = 1'b1;
          end
        end else if (is_clear) begin
          pin_d     = '0;
          pin_vld_d = 1'b0;
        end else if (is_enter) begin
          if (pin_vld_q) state_d = S_REQ;
          else           entry_error_d = 1'b1;
        end
      end
      S_REQ: begin
        req_valid_d = 1'b1;
        state_d     = S_WAIT;
        timer_d     = '0;
      end
      S_WAIT: begin
        // A result in hand is consumed even if CANCEL or the timeout coincide.
        if (auth_done) begin
          timer_d = '0;
          if (auth_ok) begin
            fail_count_d   = '0;
            session_open_d = 1'b1;
            state_d        = S_SESSION;
          end else begin
            fail_count_d = fail_next;
            if (fail_next == 4'(MAX_TRIES)) begin
              locked_d = 1'b1;
              state_d  = S_LOCKED;
            end else begin
              pin_d     = '0;
              pin_vld_d = 1'b0;
              state_d   = S_PIN;
            end
          end
        end else if (is_cancel) begin
          full_clear = 1'b1;
        end else if (timer_q == TW'(RESP_TIMEOUT - 1)) begin
          entry_error_d = 1'b1;
          full_clear    = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_SESSION: begin
        if (exit) full_clear = 1'b1;
      end
      S_LOCKED: begin
        if (timer_q == TW'(LOCK_CYCLES - 1)) begin
          fail_count_d = '0;
          full_clear   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: full_clear = 1'b1;
    endcase

    if (full_clear) begin
      state_d        = S_ACC;
      accum_d        = '0;
      cnt_d          = '0;
      acc_number_d   = '0;
      pin_d          = '0;
      pin_vld_d      = 1'b0;
      session_open_d = 1'b0;
      locked_d       = 1'b0;
      timer_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_ACC;
      accum_q        <= '0;
      cnt_q          <= '0;
      acc_number_q   <= '0;
      pin_q          <= '0;
      pin_vld_q      <= 1'b0;
      req_valid_q    <= 1'b0;
      session_open_q <= 1'b0;
      locked_q       <= 1'b0;
      entry_error_q  <= 1'b0;
      fail_count_q   <= '0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      accum_q        <= accum_d;
      cnt_q          <= cnt_d;
      acc_number_q   <= acc_number_d;
      pin_q          <= pin_d;
      pin_vld_q      <= pin_vld_d;
      req_valid_q    <= req_valid_d;
      session_open_q <= session_open_d;
      locked_q       <= locked_d;
      entry_error_q  <= entry_error_d;
      fail_count_q   <= fail_count_d;
      timer_q        <= timer_d;
    end
  end

  assign acc_number   = acc_number_q;
  assign pin          = pin_q;
  assign req_valid    = req_valid_q;
  assign session_open = session_open_q;
  assign locked       = locked_q;
  assign entry_error  = entry_error_q;
  assign fail_count   = fail_count_q;

endmodule

// File: doc/atm_key_entry.md
Name: atm_key_entry

Overview:
- Keypad front-end directly upstream of the ATM control block.
- Collects a 4-digit decimal account number and a single-digit PIN from a key stream, then issues one authentication request with a stable account/PIN.
- Consumes the pass/fail result, counts consecutive failures and locks the keypad after too many.
- Drives a session-open flag that the ATM block uses as its logged-in qualifier.

Parameters:
- MAX_TRIES, 3: consecutive failed PIN attempts before lockout (1..15).
- LOCK_CYCLES, 1000: clock cycles spent in lockout.
- RESP_TIMEOUT, 64: cycles to wait for auth_done before abandoning a request.
- IDLE_CYCLES, 6000: cycles without a key press before a partial entry is discarded.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
- key_code  in  4  0-9 = digit, 10 = CLEAR, 11 = ENTER, 12 = CANCEL; 13-15 ignored.
- auth_done  in  1  one-cycle strobe; authentication result is valid.
- auth_ok  in  1  result qualifier, sampled only when auth_done=1.
- exit  in  1  logout request from the user panel.
- acc_number  out  12  assembled account number.
- pin  out  4  assembled PIN digit.
- req_valid  out  1  one-cycle authentication request strobe.
- session_open  out  1  high while a user is logged in.
- locked  out  1  high during lockout.
- entry_error  out  1  one-cycle pulse on any rejected entry or timeout.
- fail_count  out  4  current consecutive failure count.

Behaviour:
- Reset: state=ACC, all outputs 0, accumulator, digit count and timers cleared.
- States: ACC, PIN, REQ, WAIT, SESSION, LOCKED.
- ACC (account entry):
  - Digit d: acc_accum <= acc_accum*10 + d, computed at 14 bits; digit_cnt++ (max 4).
  - A 5th or further digit is dropped silently.
  - CLEAR zeroes the accumulator and count.
  - ENTER with digit_cnt==4 and acc_accum<=4095: acc_number <= acc_accum[11:0], go to PIN.
  - ENTER otherwise: entry_error pulse, accumulator cleared, stay in ACC.
- PIN:
  - The first digit is latched to pin; further digits are ignored.
  - CLEAR un-latches the PIN.
  - ENTER with a latched PIN goes to REQ.
  - ENTER without a PIN: entry_error pulse, stay in PIN.
- CANCEL in ACC, PIN or WAIT: clear account, PIN and counts; go to ACC; no error pulse. fail_count is kept.
- REQ:
  - req_valid=1 for exactly one cycle, then WAIT.
  - acc_number and pin stay stable from REQ until the next return to ACC.
- WAIT:
  - auth_done && auth_ok: fail_count <= 0, session_open <= 1, go to SESSION.
  - auth_done && !auth_ok: fail_count++. If the new value equals MAX_TRIES, go to LOCKED; otherwise go to PIN with the PIN cleared and the account kept.
  - No auth_done within RESP_TIMEOUT cycles of entering WAIT: entry_error pulse, go to ACC. fail_count is unchanged.
  - auth_done arriving on the timeout cycle wins over the timeout.
  - Keys other than CANCEL are ignored.
- SESSION:
  - session_open=1 and all keys are ignored.
  - exit=1 clears session_open next cycle and goes to ACC with everything cleared.
  - If exit and key_valid occur in the same cycle, exit wins and the key is dropped.
- LOCKED:
  - locked=1 and keys and exit are ignored.
  - After LOCK_CYCLES cycles: locked <= 0, fail_count <= 0, go to ACC.
- Idle timeout:
  - Applies in ACC and PIN only when digit_cnt>0 or a PIN is latched.
  - The counter restarts on every key_valid.
  - After IDLE_CYCLES cycles with no key: entry_error pulse, full clear, go to ACC.
- exit outside SESSION has no effect.
- Reset asserted mid-operation overrides everything on that edge, including a pending auth_done.
- All outputs are registered; req_valid appears the cycle after the state enters REQ.

Test Plan:
- Keys 2,1,7,8,ENTER,4,ENTER -> acc_number=2178, pin=4, req_valid single pulse; then auth_done=1, auth_ok=1 -> session_open=1, fail_count=0.
- Keys 9,9,9,9,ENTER -> entry_error pulse (9999>4095), state ACC. Keys 2,1,ENTER -> entry_error (only 2 digits).
- Valid account, then three attempts each answered auth_done with auth_ok=0 -> fail_count goes 1, 2, 3 and locked=1. Keys during lockout ignored. After LOCK_CYCLES: locked=0, fail_count=0.
- Request issued, auth_done withheld for 64 cycles -> entry_error pulse, state ACC, fail_count unchanged. Repeat with auth_done on cycle 64 -> result accepted.
- In SESSION, exit=1 with key_valid=1 in the same cycle -> session_open=0 next cycle, key dropped. Then key 3 followed by IDLE_CYCLES of silence -> entry_error pulse and accumulator cleared.
- Reset (rst=0) applied in WAIT, coincident with auth_done=1 -> all outputs 0, state ACC, no session opened.
